regfile_scoreboard: RTL and testbench

//   Parametrised multi-read-port register file with write-back bypass and a per-register

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/rf_pend_counter.sv | 37 +++
 rtl/regfile_scoreboard.sv | 105 ++++++++++
 tb/tb_regfile_scoreboard.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types, reset constants and address-width helper for the
//          scoreboarded register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package regfile_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t RF_RESET_R0 = 16'h0000;
   localparam word_t RF_RESET_R1 = 16'h0001;
   localparam word_t RF_RESET_R2 = 16'h8000;
   localparam word_t RF_RESET_R3 = 16'hffff;

   // A single-entry file still needs a one-bit address port.
   function automatic int rf_addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rf_pend_counter.sv
// ============================================================================
// Module : rf_pend_counter
// Brief  : Per-register outstanding-write counter with saturation flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rf_pend_counter
   import regfile_pkg::*;
#(
   parameter int PEND_BITS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 dec,
   output logic [PEND_BITS-1:0] count,
   output logic                 sat
);

   // inc and dec together leave the count unchanged (WAW in flight).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && !dec) begin
         count <= count + PEND_BITS'(1);
      end else if (dec && !inc) begin
         count <= count - PEND_BITS'(1);
      end
   end

   assign sat = &count;

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Multi-read-port register file with pending-write scoreboard.
//          Optional same-cycle write-back forwarding: define RF_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int DEPTH     = 64,
   parameter  int NRD       = 2,
   parameter  int PEND_BITS = 2,
   localparam int AW        = rf_addr_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   output logic [NRD-1:0]       rd_busy,
   output logic                 stall,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_dst,
   output logic                 iss_ok,
   input  logic                 wb_valid,
   input  logic [AW-1:0]        wb_addr,
   input  logic [WIDTH-1:0]     wb_data,
   output logic                 err_wb
);

   localparam logic [WIDTH-1:0] RST_R0 = WIDTH'(RF_RESET_R0);
   localparam logic [WIDTH-1:0] RST_R1 = WIDTH'(RF_RESET_R1);
   localparam logic [WIDTH-1:0] RST_R2 = WIDTH'(RF_RESET_R2);
   localparam logic [WIDTH-1:0] RST_R3 = WIDTH'(RF_RESET_R3);

   logic [WIDTH-1:0]     regs [DEPTH];
   logic [PEND_BITS-1:0] pend [DEPTH];
   logic [DEPTH-1:0]     sat;
   logic [DEPTH-1:0]     claim;
   logic [DEPTH-1:0]     rel;

   assign iss_ok = !sat[iss_dst];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         regs[0] <= RST_R0;
         regs[1] <= RST_R1;
         regs[2] <= RST_R2;
         regs[3] <= RST_R3;
      end else if (wb_valid) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Write-back with nothing outstanding still lands; it only flags the error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_wb <= 1'b0;
      end else if (wb_valid && (pend[wb_addr] == '0)) begin
         err_wb <= 1'b1;
      end
   end

   for (genvar r = 0; r < DEPTH; r++) begin : g_reg
      assign claim[r] = iss_valid && iss_ok && (iss_dst == AW'(r));
      assign rel[r]   = wb_valid && (wb_addr == AW'(r)) && (pend[r] != '0);

      rf_pend_counter #(
         .PEND_BITS (PEND_BITS)
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (claim[r]),
         .dec   (rel[r]),
         .count (pend[r]),
         .sat   (sat[r])
      );
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[p*AW +: AW];
`ifdef RF_BYPASS_EN
      logic hit;
      assign hit = wb_valid && (wb_addr == addr);
      assign rd_data[p*WIDTH +: WIDTH] = hit ? wb_data : regs[addr];
      // The last outstanding write landing now resolves the hazard.
      assign rd_busy[p] = (pend[addr] != '0) && !(hit && (pend[addr] == PEND_BITS'(1)));
`else
      assign rd_data[p*WIDTH +: WIDTH] = regs[addr];
      assign rd_busy[p] = (pend[addr] != '0);
`endif
   end

   assign stall = |rd_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module : tb_regfile_scoreboard
// Brief  : Scoreboard bench for regfile_scoreboard (NRD=4), directed + random.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_scoreboard;

   localparam int WIDTH     = 16;
   localparam int DEPTH     = 64;
   localparam int NRD       = 4;
   localparam int PEND_BITS = 2;
   localparam int AW        = 6;
   localparam int PMAX      = (1 << PEND_BITS) - 1;

   localparam int S_DATA  = 0;
   localparam int S_BUSY  = 1;
   localparam int S_STALL = 2;
   localparam int S_ISSOK = 3;
   localparam int S_ERR   = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*WIDTH-1:0] rd_data;
   logic [NRD-1:0]       rd_busy;
   logic                 stall;
   logic                 iss_valid;
   logic [AW-1:0]        iss_dst;
   logic                 iss_ok;
   logic                 wb_valid;
   logic [AW-1:0]        wb_addr;
   logic [WIDTH-1:0]     wb_data;
   logic                 err_wb;

   int checks   = 0;
   int failures = 0;

   regfile_scoreboard #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .NRD       (NRD),
      .PEND_BITS (PEND_BITS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .stall     (stall),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .iss_ok    (iss_ok),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .err_wb    (err_wb)
   );

   always #5 clk = ~clk;

   // expectation queue (parallel queues: tag, selector, port, value)
   string       q_tag  [$];
   int          q_sel  [$];
   int          q_port [$];
   logic [31:0] q_exp  [$];

   // reference model
   logic [WIDTH-1:0] m_regs [DEPTH];
   int               m_pend [DEPTH];
   bit               m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input string tag, input int sel, input int port, input logic [31:0] exp);
      q_tag.push_back(tag);
      q_sel.push_back(sel);
      q_port.push_back(port);
      q_exp.push_back(exp);
   endtask

   function automatic logic [31:0] obs(input int sel, input int port);
      case (sel)
         S_DATA:  return 32'(rd_data[port*WIDTH +: WIDTH]);
         S_BUSY:  return 32'(rd_busy[port]);
         S_STALL: return 32'(stall);
         S_ISSOK: return 32'(iss_ok);
         default: return 32'(err_wb);
      endcase
   endfunction

   task automatic drain();
      while (q_tag.size() > 0) begin
         check(q_tag.pop_front(), obs(q_sel.pop_front(), q_port.pop_front()), q_exp.pop_front());
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 0;
      end
      m_regs[1] = 16'h0001;
      m_regs[2] = 16'h8000;
      m_regs[3] = 16'hffff;
      m_err = 1'b0;
   endfunction

   task automatic push_model();
      bit sb = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         logic [AW-1:0]    a;
         logic [WIDTH-1:0] d;
         bit               b;
         a = rd_addr[p*AW +: AW];
         d = m_regs[a];
         b = (m_pend[a] != 0);
`ifdef RF_BYPASS_EN
         if (wb_valid && wb_addr == a) begin
            d = wb_data;
            if (m_pend[a] == 1) b = 1'b0;
         end
`endif
         push($sformatf("m_data%0d", p), S_DATA, p, 32'(d));
         push($sformatf("m_busy%0d", p), S_BUSY, p, 32'(b));
         sb |= b;
      end
      push("m_stall", S_STALL, 0, 32'(sb));
      push("m_iss_ok", S_ISSOK, 0, 32'(m_pend[iss_dst] != PMAX));
      push("m_err_wb", S_ERR, 0, 32'(m_err));
   endtask

   function automatic void model_update();
      bit claim;
      bit rel;
      claim = iss_valid && (m_pend[iss_dst] != PMAX);
      rel   = wb_valid && (m_pend[wb_addr] != 0);
      if (wb_valid) begin
         if (m_pend[wb_addr] == 0) m_err = 1'b1;
         m_regs[wb_addr] = wb_data;
      end
      if (claim && !(rel && iss_dst == wb_addr)) m_pend[iss_dst]++;
      if (rel && !(claim && iss_dst == wb_addr)) m_pend[wb_addr]--;
   endfunction

   // entered at negedge with inputs driven; leaves at the next negedge
   task automatic cycle();
      #2;
      push_model();
      drain();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      iss_valid = 1'b0;
      wb_valid  = 1'b0;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b0;
      iss_dst  = '0;
      wb_addr  = '0;
      wb_data  = '0;
      rd_addr  = '0;
      idle();
      model_reset();
      @(negedge clk);
      push("rst_stall", S_STALL, 0, 0);
      push("rst_iss_ok", S_ISSOK, 0, 1);
      push("rst_err", S_ERR, 0, 0);
      cycle();
      reset = 1'b1;

      // 1: reset contents
      for (int p = 0; p < NRD; p++) set_rd(p, p);
      push("t1_r0", S_DATA, 0, 32'h0000);
      push("t1_r1", S_DATA, 1, 32'h0001);
      push("t1_r2", S_DATA, 2, 32'h8000);
      push("t1_r3", S_DATA, 3, 32'hffff);
      push("t1_stall", S_STALL, 0, 0);
      push("t1_err", S_ERR, 0, 0);
      cycle();

      // 2: claim r5, then dependent read and write-back
      iss_valid = 1'b1; iss_dst = 6'd5;
      push("t2_claim_ok", S_ISSOK, 0, 1);
      cycle();
      idle();
      set_rd(0, 5);
      push("t2_busy", S_BUSY, 0, 1);
      push("t2_stall", S_STALL, 0, 1);
      cycle();
      wb_valid = 1'b1; wb_addr = 6'd5; wb_data = 16'h1234;
`ifdef RF_BYPASS_EN
      push("t2_wb_busy", S_BUSY, 0, 0);
      push("t2_wb_data", S_DATA, 0, 32'h1234);
`else
      push("t2_wb_busy", S_BUSY, 0, 1);
      push("t2_wb_data", S_DATA, 0, 32'h0000);
`endif
      cycle();
      idle();
      push("t2_after_busy", S_BUSY, 0, 0);
      push("t2_after_data", S_DATA, 0, 32'h1234);
      push("t2_after_stall", S_STALL, 0, 0);
      cycle();

      // 3: saturate r7, rejected fourth claim, three releases
      iss_valid = 1'b1; iss_dst = 6'd7;
      for (int k = 0; k < 3; k++) begin
         push($sformatf("t3_claim%0d_ok", k), S_ISSOK, 0, 1);
         cycle();
      end
      push("t3_claim3_rej", S_ISSOK, 0, 0);
      cycle();
      idle();
      set_rd(0, 7);
      push("t3_busy", S_BUSY, 0, 1);
      push("t3_still_sat", S_ISSOK, 0, 0);
      cycle();
      for (int k = 1; k <= 3; k++) begin
         wb_valid = 1'b1; wb_addr = 6'd7; wb_data = 16'h0a00 + 16'(k);
`ifdef RF_BYPASS_EN
         push($sformatf("t3_wb%0d_busy", k), S_BUSY, 0, (k == 3) ? 0 : 1);
`else
         push($sformatf("t3_wb%0d_busy", k), S_BUSY, 0, 1);
`endif
         cycle();
      end
      idle();
      push("t3_done_busy", S_BUSY, 0, 0);
      push("t3_done_data", S_DATA, 0, 32'h0a03);
      push("t3_done_ok", S_ISSOK, 0, 1);
      push("t3_err", S_ERR, 0, 0);
      cycle();

      // 4: simultaneous claim and release of r9
      iss_valid = 1'b1; iss_dst = 6'd9;
      cycle();
      wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 16'h0909;
      set_rd(0, 9);
      push("t4_ok", S_ISSOK, 0, 1);
      cycle();
      idle();
      push("t4_busy", S_BUSY, 0, 1);
      push("t4_data", S_DATA, 0, 32'h0909);
      cycle();
      wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 16'h0990;
      cycle();
      idle();
      push("t4_clear_busy", S_BUSY, 0, 0);
      push("t4_clear_data", S_DATA, 0, 32'h0990);
      push("t4_err", S_ERR, 0, 0);
      cycle();

      // 5: unclaimed write-back sets sticky error
      set_rd(0, 12);
      wb_valid = 1'b1; wb_addr = 6'd12; wb_data = 16'h0c0c;
      push("t5_err_before", S_ERR, 0, 0);
      cycle();
      idle();
      push("t5_data", S_DATA, 0, 32'h0c0c);
      push("t5_err", S_ERR, 0, 1);
      cycle();
      push("t5_err_held", S_ERR, 0, 1);
      cycle();

      // 6: asynchronous reset mid-operation
      iss_valid = 1'b1; iss_dst = 6'd4;
      cycle();
      cycle();
      iss_dst = 6'd6;
      wb_valid = 1'b1; wb_addr = 6'd4; wb_data = 16'hbeef;
      cycle();
      idle();
      set_rd(0, 4); set_rd(1, 6);
      push("t6_busy0", S_BUSY, 0, 1);
      push("t6_busy1", S_BUSY, 1, 1);
      push("t6_data0", S_DATA, 0, 32'hbeef);
      push("t6_stall", S_STALL, 0, 1);
      cycle();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      push("t6_rst_busy0", S_BUSY, 0, 0);
      push("t6_rst_busy1", S_BUSY, 1, 0);
      push("t6_rst_stall", S_STALL, 0, 0);
      push("t6_rst_data0", S_DATA, 0, 32'h0000);
      push("t6_rst_err", S_ERR, 0, 0);
      push_model();
      drain();
      @(negedge clk);
      reset = 1'b1;
      push("t6_post_busy0", S_BUSY, 0, 0);
      cycle();

      // random sweep on a small register window for frequent hazards
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 15));
         iss_valid = 1'($urandom_range(0, 1));
         iss_dst   = AW'($urandom_range(0, 15));
         wb_valid  = ($urandom_range(0, 9) < 4);
         wb_addr   = AW'($urandom_range(0, 15));
         wb_data   = WIDTH'($urandom);
         cycle();
      end
      idle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
